// File: rtl/step_motor_pkg.sv
// Shared definitions for the stepper pulse/direction generator: FSM encoding,
// minimum step period and synchronizer depth.
package step_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/step_motor_driver_if.sv
// Command/status bundle between a motor control port of the CPU and one
// step_motor_driver instance.
interface step_motor_driver_if #(
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_STEP_NUMBER_WIDTH = 32
);

  logic                           ctl_start;
  logic                           ctl_stop;
  logic [C_SPEED_DATA_WIDTH-1:0]  ctl_speed;
  logic [C_STEP_NUMBER_WIDTH-1:0] ctl_step;
  logic                           ctl_dir;
  logic                           ctl_mod_remain;
  logic [C_STEP_NUMBER_WIDTH-1:0] ctl_new_remain;
  logic                           ctl_state;
  logic [C_SPEED_DATA_WIDTH-1:0]  ctl_rt_speed;
  logic [C_STEP_NUMBER_WIDTH-1:0] ctl_position;
  logic                           ctl_zpsign;
  logic                           ctl_tpsign;

  modport master (
    output ctl_start, ctl_stop, ctl_speed, ctl_step, ctl_dir,
           ctl_mod_remain, ctl_new_remain,
    input  ctl_state, ctl_rt_speed, ctl_position, ctl_zpsign, ctl_tpsign
  );

  modport slave (
    input  ctl_start, ctl_stop, ctl_speed, ctl_step, ctl_dir,
           ctl_mod_remain, ctl_new_remain,
    output ctl_state, ctl_rt_speed, ctl_position, ctl_zpsign, ctl_tpsign
  );

endinterface

// File: rtl/sig_sync.sv
// Multi-flop synchronizer bringing an asynchronous limit sensor into the clk domain.
module sig_sync
  import step_motor_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], din};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/step_motor_driver.sv
// STEP/DIR pulse generator for one motor axis: latches a move command, emits
// fixed-period step pulses, tracks absolute position and honours limit sensors.
module step_motor_driver
  import step_motor_pkg::*;
#(
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_STEP_NUMBER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  step_motor_driver_if.slave  ctl,
  input  logic                zpd,
  input  logic                tpd,
  output logic                drv_pulse,
  output logic                drv_dir
);

  localparam int SW = C_SPEED_DATA_WIDTH;
  localparam int NW = C_STEP_NUMBER_WIDTH;

  state_e                state_q,  state_d;
  logic [SW-1:0]         period_q, period_d;
  logic [SW-1:0]         cnt_q,    cnt_d;
  logic [NW-1:0]         remain_q, remain_d;
  logic signed [NW-1:0]  pos_q,    pos_d;
  logic                  dir_q,    dir_d;
  logic                  stop_q,   stop_d;
  logic                  pulse_q,  pulse_d;

  logic zp_sync;
  logic tp_sync;
  logic start_ok;
  logic limit_hit;
  logic period_end;

  function automatic logic [SW-1:0] clamp_period(input logic [SW-1:0] spd);
    if (spd < SW'(MIN_PERIOD)) begin
      return SW'(MIN_PERIOD);
    end
    return spd;
  endfunction

  function automatic logic signed [NW-1:0] step_position(
    input logic signed [NW-1:0] pos,
    input logic                 dir
  );
    if (dir) begin
      return pos + NW'(1);
    end
    return pos - NW'(1);
  endfunction

  sig_sync u_zp_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (zpd),
    .dout   (zp_sync)
  );

  sig_sync u_tp_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (tpd),
    .dout   (tp_sync)
  );

  // A start never launches a move that would immediately drive into the sensor it targets.
  assign start_ok   = ctl.ctl_start && !ctl.ctl_stop && (ctl.ctl_step != '0) &&
                      !(ctl.ctl_dir ? tp_sync : zp_sync);
  assign limit_hit  = dir_q ? tp_sync : zp_sync;
  assign period_end = (cnt_q == period_q - SW'(1));

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    stop_d   = stop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_SETUP;
          period_d = clamp_period(ctl.ctl_speed);
          remain_d = ctl.ctl_step;
          dir_d    = ctl.ctl_dir;
          stop_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ctl.ctl_stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // cnt_q == 0 is the cycle the STEP pin is high for the first time this period.
        if (cnt_q == '0) begin
          remain_d = remain_q - NW'(1);
          pos_d    = step_position(pos_q, dir_q);
        end
        if (ctl.ctl_stop) begin
          stop_d = 1'b1;
        end else if (ctl.ctl_mod_remain) begin
          remain_d = ctl.ctl_new_remain;
        end
        if (period_end) begin
          cnt_d = '0;
          if ((remain_d == '0) || stop_d || limit_hit) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
            if (!dir_q && zp_sync) begin
              pos_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pulse_d = (state_d == ST_RUN) && (cnt_d < (period_d >> 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      remain_q <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      stop_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      stop_q   <= stop_d;
      pulse_q  <= pulse_d;
    end
  end

  assign drv_pulse        = pulse_q;
  assign drv_dir          = dir_q;
  assign ctl.ctl_state    = (state_q != ST_IDLE);
  assign ctl.ctl_rt_speed = (state_q != ST_IDLE) ? period_q : '0;
  assign ctl.ctl_position = pos_q;
  assign ctl.ctl_zpsign   = zp_sync;
  assign ctl.ctl_tpsign   = tp_sync;

endmodule

// File: tb/tb_step_motor_driver.sv
// Directed bench for step_motor_driver: pulse shape, counts, stop/modify,
// limit handling, reset and rejection cases.
module tb_step_motor_driver;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic zpd = 1'b0;
  logic tpd = 1'b0;
  logic drv_pulse;
  logic drv_dir;

  int checks = 0;
  int errors = 0;

  step_motor_driver_if #(.C_SPEED_DATA_WIDTH(32), .C_STEP_NUMBER_WIDTH(32)) ifc ();

  step_motor_driver #(.C_SPEED_DATA_WIDTH(32), .C_STEP_NUMBER_WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ctl       (ifc.slave),
    .zpd       (zpd),
    .tpd       (tpd),
    .drv_pulse (drv_pulse),
    .drv_dir   (drv_dir)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ifc.ctl_start = 1'b0;
    ifc.ctl_stop = 1'b0;
    ifc.ctl_speed = '0;
    ifc.ctl_step = '0;
    ifc.ctl_dir = 1'b0;
    ifc.ctl_mod_remain = 1'b0;
    ifc.ctl_new_remain = '0;
    zpd = 1'b0;
    tpd = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  // Pulses ctl_start for one cycle; returns in the cycle after the request.
  task automatic issue_start(input logic [31:0] spd, input logic [31:0] stp,
                             input logic dir, input logic with_stop);
    ifc.ctl_speed = spd;
    ifc.ctl_step = stp;
    ifc.ctl_dir = dir;
    ifc.ctl_start = 1'b1;
    ifc.ctl_stop = with_stop;
    tick();
    ifc.ctl_start = 1'b0;
    ifc.ctl_stop = 1'b0;
  endtask

  // Follows a move from its SETUP cycle (index 0) until ctl_state drops,
  // injecting stop/modify/zero-point events at given indices.
  task automatic observe(input int budget, input int stop_at, input int mod_at,
                         input logic [31:0] mod_val, input int zp_at,
                         output int st_cyc, output int rises,
                         output int hi_min, output int hi_max,
                         output int lo_min, output int lo_max,
                         output bit timed_out);
    int run;
    logic prev;
    bit seen;
    st_cyc = 0; rises = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    run = 0; prev = 1'b0; seen = 1'b0; timed_out = 1'b0;
    while (ifc.ctl_state === 1'b1) begin
      if (st_cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      ifc.ctl_stop = (st_cyc == stop_at);
      ifc.ctl_mod_remain = (st_cyc == mod_at);
      ifc.ctl_new_remain = mod_val;
      if (st_cyc == zp_at) zpd = 1'b1;
      if (drv_pulse !== prev) begin
        if (prev) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else if (seen) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        if (drv_pulse) begin
          rises++;
          seen = 1'b1;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = drv_pulse;
      st_cyc++;
      tick();
    end
    if (seen && !prev) begin
      if (run < lo_min) lo_min = run;
      if (run > lo_max) lo_max = run;
    end
    ifc.ctl_stop = 1'b0;
    ifc.ctl_mod_remain = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifc.ctl_state !== 1'b0) begin errors++; $display("FAIL reset_state got %0b want 0", ifc.ctl_state); end
    checks++; if (ifc.ctl_rt_speed !== 32'd0) begin errors++; $display("FAIL reset_rt_speed got %0d want 0", ifc.ctl_rt_speed); end
    checks++; if (ifc.ctl_position !== 32'd0) begin errors++; $display("FAIL reset_position got %0d want 0", ifc.ctl_position); end
    checks++; if (drv_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", drv_pulse); end
    checks++; if (drv_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %0b want 0", drv_dir); end
    checks++; if (ifc.ctl_zpsign !== 1'b0 || ifc.ctl_tpsign !== 1'b0) begin errors++; $display("FAIL reset_signs got %0b%0b want 00", ifc.ctl_zpsign, ifc.ctl_tpsign); end
  endtask

  task automatic test_first_pulse();
    do_reset();
    issue_start(32'd4, 32'd1, 1'b1, 1'b0);
    checks++; if (ifc.ctl_state !== 1'b1) begin errors++; $display("FAIL setup_state got %0b want 1", ifc.ctl_state); end
    checks++; if (ifc.ctl_rt_speed !== 32'd4) begin errors++; $display("FAIL setup_rt_speed got %0d want 4", ifc.ctl_rt_speed); end
    checks++; if (drv_dir !== 1'b1) begin errors++; $display("FAIL setup_dir got %0b want 1", drv_dir); end
    checks++; if (drv_pulse !== 1'b0) begin errors++; $display("FAIL setup_pulse got %0b want 0", drv_pulse); end
    tick();
    checks++; if (drv_pulse !== 1'b1 || ifc.ctl_position !== 32'd0) begin errors++; $display("FAIL rise_cycle got pulse %0b pos %0d want 1 0", drv_pulse, ifc.ctl_position); end
    tick();
    checks++; if (drv_pulse !== 1'b1 || ifc.ctl_position !== 32'd1) begin errors++; $display("FAIL after_rise got pulse %0b pos %0d want 1 1", drv_pulse, ifc.ctl_position); end
    tick();
    checks++; if (drv_pulse !== 1'b0) begin errors++; $display("FAIL low_phase got %0b want 0", drv_pulse); end
    tick();
    checks++; if (ifc.ctl_state !== 1'b1 || drv_pulse !== 1'b0) begin errors++; $display("FAIL last_cycle got state %0b pulse %0b want 1 0", ifc.ctl_state, drv_pulse); end
    tick();
    checks++; if (ifc.ctl_state !== 1'b0 || ifc.ctl_rt_speed !== 32'd0) begin errors++; $display("FAIL end_idle got state %0b rt %0d want 0 0", ifc.ctl_state, ifc.ctl_rt_speed); end
    checks++; if (drv_dir !== 1'b1 || ifc.ctl_position !== 32'd1) begin errors++; $display("FAIL end_hold got dir %0b pos %0d want 1 1", drv_dir, ifc.ctl_position); end
  endtask

  task automatic test_basic_move();
    int st, r, hmin, hmax, lmin, lmax;
    bit to;
    do_reset();
    issue_start(32'd10, 32'd3, 1'b1, 1'b0);
    checks++; if (ifc.ctl_rt_speed !== 32'd10) begin errors++; $display("FAIL basic_rt_speed got %0d want 10", ifc.ctl_rt_speed); end
    observe(400, -1, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got state stuck want idle"); end
    checks++; if (st !== 31) begin errors++; $display("FAIL basic_state_len got %0d want 31", st); end
    checks++; if (r !== 3) begin errors++; $display("FAIL basic_pulses got %0d want 3", r); end
    checks++; if (hmin !== 5 || hmax !== 5 || lmin !== 5 || lmax !== 5) begin errors++; $display("FAIL basic_shape got hi %0d..%0d lo %0d..%0d want 5 5", hmin, hmax, lmin, lmax); end
    checks++; if (ifc.ctl_position !== 32'd3 || ifc.ctl_rt_speed !== 32'd0) begin errors++; $display("FAIL basic_end got pos %0d rt %0d want 3 0", ifc.ctl_position, ifc.ctl_rt_speed); end
  endtask

  task automatic test_min_period();
    int st, r, hmin, hmax, lmin, lmax;
    bit to;
    do_reset();
    issue_start(32'd0, 32'd2, 1'b1, 1'b0);
    checks++; if (ifc.ctl_rt_speed !== 32'd2) begin errors++; $display("FAIL clamp_rt_speed got %0d want 2", ifc.ctl_rt_speed); end
    observe(400, -1, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 5 || r !== 2) begin errors++; $display("FAIL clamp_len got len %0d pulses %0d to %0b want 5 2 0", st, r, to); end
    checks++; if (hmin !== 1 || hmax !== 1 || lmin !== 1 || lmax !== 1) begin errors++; $display("FAIL clamp_shape got hi %0d..%0d lo %0d..%0d want 1 1", hmin, hmax, lmin, lmax); end
    checks++; if (ifc.ctl_position !== 32'd2) begin errors++; $display("FAIL clamp_pos got %0d want 2", ifc.ctl_position); end
  endtask

  task automatic test_stop();
    int st, r, hmin, hmax, lmin, lmax;
    bit to;
    do_reset();
    issue_start(32'd8, 32'd100, 1'b1, 1'b0);
    // Pulse 4 is high at indices 25..28; stop lands in the middle of it.
    observe(400, 26, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 33 || r !== 4) begin errors++; $display("FAIL stop_len got len %0d pulses %0d to %0b want 33 4 0", st, r, to); end
    checks++; if (hmin !== 4 || hmax !== 4 || lmin !== 4 || lmax !== 4) begin errors++; $display("FAIL stop_shape got hi %0d..%0d lo %0d..%0d want 4 4", hmin, hmax, lmin, lmax); end
    checks++; if (ifc.ctl_position !== 32'd4) begin errors++; $display("FAIL stop_pos got %0d want 4", ifc.ctl_position); end
  endtask

  task automatic test_mod_remain();
    int st, r, hmin, hmax, lmin, lmax;
    bit to;
    do_reset();
    issue_start(32'd6, 32'd10, 1'b1, 1'b0);
    observe(400, -1, 11, 32'd1, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 19 || r !== 3) begin errors++; $display("FAIL mod1_len got len %0d pulses %0d to %0b want 19 3 0", st, r, to); end
    checks++; if (ifc.ctl_position !== 32'd3) begin errors++; $display("FAIL mod1_pos got %0d want 3", ifc.ctl_position); end
    do_reset();
    issue_start(32'd6, 32'd10, 1'b1, 1'b0);
    observe(400, -1, 11, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 13 || r !== 2) begin errors++; $display("FAIL mod0_len got len %0d pulses %0d to %0b want 13 2 0", st, r, to); end
    checks++; if (ifc.ctl_position !== 32'd2) begin errors++; $display("FAIL mod0_pos got %0d want 2", ifc.ctl_position); end
    do_reset();
    issue_start(32'd6, 32'd10, 1'b1, 1'b0);
    observe(400, 11, 11, 32'd5, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 13 || r !== 2) begin errors++; $display("FAIL stop_over_mod got len %0d pulses %0d to %0b want 13 2 0", st, r, to); end
  endtask

  task automatic test_zero_point();
    int st, r, hmin, hmax, lmin, lmax;
    bit to;
    do_reset();
    issue_start(32'd4, 32'd5, 1'b1, 1'b0);
    observe(400, -1, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 21 || ifc.ctl_position !== 32'd5) begin errors++; $display("FAIL zp_prep got len %0d pos %0d want 21 5", st, ifc.ctl_position); end
    issue_start(32'd10, 32'd20, 1'b0, 1'b0);
    observe(400, -1, -1, 32'd0, 27, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 31 || r !== 3) begin errors++; $display("FAIL zp_len got len %0d pulses %0d to %0b want 31 3 0", st, r, to); end
    checks++; if (ifc.ctl_position !== 32'd0) begin errors++; $display("FAIL zp_clear got %0d want 0", ifc.ctl_position); end
    checks++; if (ifc.ctl_zpsign !== 1'b1 || drv_dir !== 1'b0) begin errors++; $display("FAIL zp_flags got zp %0b dir %0b want 1 0", ifc.ctl_zpsign, drv_dir); end
    issue_start(32'd4, 32'd3, 1'b0, 1'b0);
    checks++; if (ifc.ctl_state !== 1'b0) begin errors++; $display("FAIL zp_reject got state %0b want 0", ifc.ctl_state); end
    repeat (4) tick();
    checks++; if (drv_pulse !== 1'b0 || ifc.ctl_position !== 32'd0) begin errors++; $display("FAIL zp_reject_quiet got pulse %0b pos %0d want 0 0", drv_pulse, ifc.ctl_position); end
    issue_start(32'd2, 32'd1, 1'b1, 1'b0);
    checks++; if (ifc.ctl_state !== 1'b1) begin errors++; $display("FAIL zp_leave_accept got state %0b want 1", ifc.ctl_state); end
    observe(400, -1, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || st !== 3 || ifc.ctl_position !== 32'd1) begin errors++; $display("FAIL zp_leave got len %0d pos %0d want 3 1", st, ifc.ctl_position); end
    zpd = 1'b0;
  endtask

  task automatic test_rejects();
    do_reset();
    issue_start(32'd4, 32'd3, 1'b1, 1'b1);
    checks++; if (ifc.ctl_state !== 1'b0) begin errors++; $display("FAIL start_stop_same got state %0b want 0", ifc.ctl_state); end
    issue_start(32'd4, 32'd0, 1'b1, 1'b0);
    checks++; if (ifc.ctl_state !== 1'b0) begin errors++; $display("FAIL zero_steps got state %0b want 0", ifc.ctl_state); end
    tpd = 1'b1;
    tick();
    checks++; if (ifc.ctl_tpsign !== 1'b0) begin errors++; $display("FAIL sync_lat1 got %0b want 0", ifc.ctl_tpsign); end
    tick();
    checks++; if (ifc.ctl_tpsign !== 1'b1) begin errors++; $display("FAIL sync_lat2 got %0b want 1", ifc.ctl_tpsign); end
    issue_start(32'd4, 32'd3, 1'b1, 1'b0);
    checks++; if (ifc.ctl_state !== 1'b0) begin errors++; $display("FAIL tp_reject got state %0b want 0", ifc.ctl_state); end
    repeat (3) tick();
    checks++; if (drv_pulse !== 1'b0 || ifc.ctl_position !== 32'd0) begin errors++; $display("FAIL reject_quiet got pulse %0b pos %0d want 0 0", drv_pulse, ifc.ctl_position); end
    tpd = 1'b0;
  endtask

  task automatic test_wrap();
    int st, r, hmin, hmax, lmin, lmax;
    bit to;
    do_reset();
    issue_start(32'd2, 32'd1, 1'b0, 1'b0);
    observe(400, -1, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || ifc.ctl_position !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_down got %h want ffffffff", ifc.ctl_position); end
    issue_start(32'd2, 32'd1, 1'b1, 1'b0);
    observe(400, -1, -1, 32'd0, -1, st, r, hmin, hmax, lmin, lmax, to);
    checks++; if (to || ifc.ctl_position !== 32'd0) begin errors++; $display("FAIL wrap_up got %h want 0", ifc.ctl_position); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    issue_start(32'd10, 32'd5, 1'b1, 1'b0);
    repeat (3) tick();
    checks++; if (drv_pulse !== 1'b1 || ifc.ctl_position !== 32'd1) begin errors++; $display("FAIL pre_reset got pulse %0b pos %0d want 1 1", drv_pulse, ifc.ctl_position); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (drv_pulse !== 1'b0 || ifc.ctl_state !== 1'b0) begin errors++; $display("FAIL async_reset got pulse %0b state %0b want 0 0", drv_pulse, ifc.ctl_state); end
    checks++; if (ifc.ctl_position !== 32'd0 || ifc.ctl_rt_speed !== 32'd0) begin errors++; $display("FAIL async_reset_pos got pos %0d rt %0d want 0 0", ifc.ctl_position, ifc.ctl_rt_speed); end
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    checks++; if (ifc.ctl_state !== 1'b0 || drv_pulse !== 1'b0) begin errors++; $display("FAIL post_reset got state %0b pulse %0b want 0 0", ifc.ctl_state, drv_pulse); end
  endtask

  initial begin
    test_reset();
    test_first_pulse();
    test_basic_move();
    test_min_period();
    test_stop();
    test_mod_remain();
    test_zero_point();
    test_rejects();
    test_wrap();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_motor_driver.md
# step_motor_driver

Pulse/direction generator sitting directly downstream of each motor control port of the fusion-splicer CPU. It consumes the start/stop/speed/step/dir/remain-modify command bundle, drives a stepper driver's STEP/DIR pins at a fixed period, tracks absolute position, and returns run state, real-time speed, position and synchronized zero-point/terminal-point limit flags. One instance per motor (left, right, X, Y).

## Interface
- C_SPEED_DATA_WIDTH, 32, step period in clk cycles (ctl_speed width)
- C_STEP_NUMBER_WIDTH, 32, step count / position width
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- ctl_start  in  1  one-cycle start request
- ctl_stop  in  1  one-cycle stop request
- ctl_speed  in  C_SPEED_DATA_WIDTH  step period in clk cycles, latched at start
- ctl_step  in  C_STEP_NUMBER_WIDTH  number of steps, latched at start
- ctl_dir  in  1  1 = toward terminal point (position increments), 0 = toward zero point
- ctl_mod_remain  in  1  one-cycle request to overwrite remaining step count
- ctl_new_remain  in  C_STEP_NUMBER_WIDTH  new remaining count
- ctl_state  out  1  1 while moving
- ctl_rt_speed  out  C_SPEED_DATA_WIDTH  latched period while moving, 0 idle
- ctl_position  out  C_STEP_NUMBER_WIDTH  absolute position, two's complement
- ctl_zpsign  out  1  synchronized zero-point sensor
- ctl_tpsign  out  1  synchronized terminal-point sensor
- zpd  in  1  raw zero-point sensor, active-high, asynchronous
- tpd  in  1  raw terminal-point sensor, active-high, asynchronous
- drv_pulse  out  1  STEP pin
- drv_dir  out  1  DIR pin

## Operation
- States: IDLE, SETUP, RUN. Reset: IDLE, all outputs 0, position 0.
- IDLE: ctl_start accepted unless ctl_step==0, or ctl_dir==0 with ctl_zpsign=1, or ctl_dir==1 with ctl_tpsign=1 (rejected: stays IDLE, no pulse). On accept latch period = max(ctl_speed,2), remain = ctl_step, dir; go SETUP. ctl_stop/ctl_mod_remain ignored in IDLE; start+stop same cycle: start ignored.
- SETUP: one cycle, drv_dir valid before first pulse; go RUN.
- RUN: each period = period cycles; drv_pulse high first floor(period/2) cycles, low remainder. At each rising edge remain decrements and position ±1 per dir.
- Period boundary exits to IDLE when remain==0, or stop pending, or limit hit (dir==0 and zpsign, dir==1 and tpsign). Pulses are never truncated.
- ctl_stop in RUN: sets stop pending; no further rising edges.
- ctl_mod_remain in RUN: remain := ctl_new_remain (counts future pulses); 0 means end at current boundary. Same cycle as ctl_stop: stop wins. ctl_start in SETUP/RUN ignored.
- Zero-point exit (dir==0, zpsign): position cleared to 0 on the IDLE-entry cycle.
- Position wraps modulo 2^C_STEP_NUMBER_WIDTH.

## Timing
- zpd/tpd → ctl_zpsign/ctl_tpsign: 2-flop synchronizer, 2-cycle latency.
- ctl_start at cycle N: ctl_state=1, ctl_rt_speed, drv_dir valid at N+1 (SETUP); first drv_pulse rise at N+2.
- ctl_position updates the cycle after each rising edge of drv_pulse.
- Last period ends at cycle E: ctl_state=0, ctl_rt_speed=0 at E+1; drv_dir holds last value.
- Step count k, period p: ctl_state high exactly 1 + k·p cycles.
- resetn low mid-move: immediate IDLE, drv_pulse=0, position 0.

## Structure
- Shared package step_motor_pkg: state encoding (IDLE/SETUP/RUN), minimum period constant 2, sync depth 2.
- One sub-module: sig_sync (2-flop synchronizer), instanced for zpd and tpd.
- Remainder: one state register, period counter, remain counter, position counter.

## Test plan
- Start speed=10, step=3, dir=1 → 3 pulses, each high 5/low 5, ctl_state high 31 cycles, position 0→3, rt_speed 10 then 0.
- Start speed=0, step=2 → period clamped to 2: pulses high 1/low 1, ctl_state high 5 cycles.
- Start step=100 speed=8, ctl_stop mid-high-phase of pulse 4 → pulse 4 completes full 8 cycles, exactly 4 pulses, position=4.
- Start step=10, after pulse 2 ctl_mod_remain new_remain=1 → total 3 pulses; repeat with new_remain=0 → 2 pulses.
- Position 5, dir=0 step=20, raise zpd after pulse 3 → motion ends at period boundary after sync, position 0; then start dir=0 rejected, start dir=1 accepted.
- resetn low during RUN → drv_pulse, ctl_state, ctl_position 0 immediately; start+stop same cycle in IDLE → no motion.
